// File: rtl/tristate_bus_arbiter_if.sv
// Shared-bus arbitration interface: requests in, grants and TINV enables out.
interface tristate_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] REQ;
  logic [N_REQ-1:0] GNT;
  logic [N_REQ-1:0] EN;
  logic [N_REQ-1:0] nEN;
  logic [OW-1:0]    OWNER;
  logic             BUS_IDLE;

  // Requester side
  modport master (
    output REQ,
    input  GNT, EN, nEN, OWNER, BUS_IDLE
  );

  // Arbiter side
  modport slave (
    input  REQ,
    output GNT, EN, nEN, OWNER, BUS_IDLE
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a TINV-driven shared bus with bounded hold time
// and a fixed all-drivers-off turnaround between owners.
module tristate_bus_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  tristate_bus_arbiter_if.slave bus
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = 8;
  localparam int unsigned TW = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] en_q, en_d;
  logic [N_REQ-1:0] nen_q, nen_d;
  logic             bus_idle_q, bus_idle_d;

  logic [OW:0]      pick;
  logic             win_found;
  logic [OW-1:0]    win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [HW-1:0]    hold_inc;
  logic             others_pending;
  logic             release_bus;

  // First asserted request at or after start, wrapping modulo N_REQ
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [OW-1:0]    start);
    logic [OW:0]   res;
    int unsigned   idx;
    logic [OW-1:0] sel;
    res = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = 32'(start) + unsigned'(i);
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = OW'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  // Arbitration result and grant-phase release conditions
  always_comb begin
    pick           = rr_pick(bus.REQ, ptr_q);
    win_found      = pick[OW];
    win_idx        = pick[OW-1:0];
    win_oh         = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    hold_inc       = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    others_pending = |(bus.REQ & ~gnt_q);
    release_bus    = !bus.REQ[owner_q] ||
                     ((hold_inc == HW'(MAX_HOLD)) && others_pending);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    gnt_d      = gnt_q;
    en_d       = en_q;
    nen_d      = nen_q;
    bus_idle_d = bus_idle_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_GRANT;
          owner_d    = win_idx;
          hold_d     = '0;
          gnt_d      = win_oh;
          en_d       = win_oh;
          nen_d      = ~win_oh;
          bus_idle_d = 1'b0;
        end
      end

      ST_GRANT: begin
        hold_d = hold_inc;
        if (release_bus) begin
          state_d    = ST_TURN;
          turn_d     = '0;
          ptr_d      = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          gnt_d      = '0;
          en_d       = '0;
          nen_d      = '1;
          bus_idle_d = 1'b1;
        end
      end

      ST_TURN: begin
        if (turn_q == TW'(TURNAROUND - 1)) begin
          if (win_found) begin
            state_d    = ST_GRANT;
            owner_d    = win_idx;
            hold_d     = '0;
            gnt_d      = win_oh;
            en_d       = win_oh;
            nen_d      = ~win_oh;
            bus_idle_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        en_d       = '0;
        nen_d      = '1;
        bus_idle_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
      turn_q     <= '0;
      gnt_q      <= '0;
      en_q       <= '0;
      nen_q      <= '1;
      bus_idle_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      gnt_q      <= gnt_d;
      en_q       <= en_d;
      nen_q      <= nen_d;
      bus_idle_q <= bus_idle_d;
    end
  end

  assign bus.GNT      = gnt_q;
  assign bus.EN       = en_q;
  assign bus.nEN      = nen_q;
  assign bus.OWNER    = owner_q;
  assign bus.BUS_IDLE = bus_idle_q;

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one TINV-driven bus, legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles while another requester is pending, legal range 1..255.
REQ-003 Parameter TURNAROUND, default 1: dead cycles with all drivers disabled between owners, legal range 1..7.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ  input  N_REQ  per-requester bus request, level-sensitive, held high for the whole transfer.
REQ-007 GNT  output  N_REQ  one-hot grant, registered.
REQ-008 EN  output  N_REQ  TINV enable per driver, registered.
REQ-009 nEN  output  N_REQ  complementary TINV enable, registered, bitwise inverse of EN every cycle.
REQ-010 OWNER  output  clog2(N_REQ)  index of current or most recent owner.
REQ-011 BUS_IDLE  output  1  high when no driver is enabled.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, TURN.
REQ-013 Arbitration SHALL be round-robin: search starts at pointer PTR and wraps modulo N_REQ; the first asserted REQ wins.
REQ-014 In IDLE with any REQ high at edge k, the FSM SHALL enter GRANT, with GNT[w], EN[w] high and nEN[w] low visible after edge k (one-cycle latency).
REQ-015 In IDLE with no REQ, all outputs SHALL hold their idle values.
REQ-016 In GRANT, a hold counter SHALL increment each cycle, saturating at MAX_HOLD.
REQ-017 GRANT SHALL be left for TURN when REQ[OWNER] is sampled low.
REQ-018 GRANT SHALL also be left for TURN when hold count equals MAX_HOLD and any other REQ is high (pre-emption).
REQ-019 With no competing request, the owner SHALL keep the bus indefinitely.
REQ-020 On entering TURN, GNT and EN SHALL go all-zero, nEN all-ones, and PTR SHALL become (OWNER+1) mod N_REQ.
REQ-021 TURN SHALL last exactly TURNAROUND cycles, during which REQ is ignored.
REQ-022 At the last TURN cycle, any high REQ SHALL be arbitrated from the new PTR and move the FSM directly to GRANT; otherwise the FSM SHALL go to IDLE.
REQ-023 At most one EN bit SHALL be high in any cycle.
REQ-024 Two different EN bits SHALL never be high with fewer than TURNAROUND all-low cycles between them.
REQ-025 When the owner is released and re-requests at the end of TURN, the owner SHALL be re-granted only if no requester between PTR and it is pending.
REQ-026 A pre-empted requester that keeps REQ high SHALL be re-granted in round-robin order without dropping REQ.
REQ-027 BUS_IDLE SHALL equal NOR of EN.
REQ-028 OWNER SHALL update only on a new grant.
REQ-029 The hold counter SHALL clear on every new grant.

Reset
REQ-030 RST high at an edge SHALL force IDLE, PTR=0, OWNER=0, hold counter=0, GNT=0, EN=0, nEN=all-ones, BUS_IDLE=1, overriding all other inputs.
REQ-031 RST asserted mid-GRANT SHALL disable the driver at that edge with no turnaround; after RST falls, arbitration SHALL restart from PTR=0.

Verification
REQ-032 Reset, then REQ=4'b0100 -> after 1 edge GNT=4'b0100, EN=4'b0100, nEN=4'b1011, OWNER=2, BUS_IDLE=0.
REQ-033 REQ=4'b1111 held, MAX_HOLD=8, TURNAROUND=1 -> grants 0,1,2,3,0 in order, each 8 cycles, each followed by 1 all-low cycle.
REQ-034 Owner 1 drops REQ while REQ[3] high -> 1 TURN cycle with EN=0, then GNT=4'b1000.
REQ-035 Single requester 0 holds REQ for 50 cycles -> GNT stays 4'b0001 for all 50 cycles, no pre-emption.
REQ-036 RST pulsed during GRANT of requester 2 -> EN=0 and nEN=4'b1111 after that edge; with REQ=4'b0101 afterwards, grant goes to 0.
REQ-037 Random REQ for 10k cycles -> checker confirms REQ-023, REQ-024 and nEN==~EN on every cycle.
